// File: rtl/pattern_scan_arbiter.sv
// Round-robin arbiter sharing one serial MSB-first pattern matcher between NUM_REQ byte streams.
// Each channel keeps its own bit history so matches can span consecutive bytes of that channel.
module pattern_scan_arbiter #(
    parameter int unsigned       NUM_REQ = 4,
    parameter int unsigned       PAT_W   = 6,
    parameter logic [PAT_W-1:0]  PATTERN = 6'b110101,
    parameter int unsigned       ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] data,
    input  logic [NUM_REQ-1:0]   hist_clr,
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 busy,
    output logic                 done,
    output logic [ID_W-1:0]      done_id,
    output logic [3:0]           match_cnt
);

    localparam int unsigned HIST_W = PAT_W - 1;
    localparam int unsigned FILL_W = 4;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               state_q, state_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [ID_W-1:0]      cur_q, cur_d;
    logic [7:0]           byte_q, byte_d;
    logic [2:0]           bit_q, bit_d;
    logic [HIST_W-1:0]    work_hist_q, work_hist_d;
    logic [FILL_W-1:0]    work_fill_q, work_fill_d;
    logic [CNT_W-1:0]     work_cnt_q, work_cnt_d;
    logic                 kill_q, kill_d;
    logic [HIST_W-1:0]    hist_q [NUM_REQ];
    logic [HIST_W-1:0]    hist_d [NUM_REQ];
    logic [FILL_W-1:0]    fill_q [NUM_REQ];
    logic [FILL_W-1:0]    fill_d [NUM_REQ];
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic                 done_q, done_d;
    logic [ID_W-1:0]      done_id_q, done_id_d;
    logic [CNT_W-1:0]     match_cnt_q, match_cnt_d;

    logic                 found;
    logic [ID_W-1:0]      win;
    logic [ID_W-1:0]      idx;
    logic [PAT_W-1:0]     window;
    logic [FILL_W-1:0]    fill_nx;
    logic                 hit;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state, arbitration and matcher datapath
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cur_d       = cur_q;
        byte_d      = byte_q;
        bit_d       = bit_q;
        work_hist_d = work_hist_q;
        work_fill_d = work_fill_q;
        work_cnt_d  = work_cnt_q;
        kill_d      = kill_q;
        hist_d      = hist_q;
        fill_d      = fill_q;
        gnt_d       = '0;
        done_d      = 1'b0;
        done_id_d   = done_id_q;
        match_cnt_d = match_cnt_q;
        found       = 1'b0;
        win         = '0;
        idx         = '0;

        for (int i = 0; i < int'(NUM_REQ); i++) begin
            idx = ID_W'((int'(ptr_q) + i) % int'(NUM_REQ));
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end

        window  = {work_hist_q, byte_q[7]};
        fill_nx = (work_fill_q >= FILL_W'(PAT_W)) ? FILL_W'(PAT_W) : work_fill_q + FILL_W'(1);
        hit     = (window == PATTERN) && (fill_nx >= FILL_W'(PAT_W));

        case (state_q)
            IDLE: begin
                if (found) begin
                    cur_d       = win;
                    byte_d      = data[8*win +: 8];
                    bit_d       = '0;
                    work_hist_d = hist_q[win];
                    work_fill_d = fill_q[win];
                    work_cnt_d  = '0;
                    kill_d      = hist_clr[win];
                    gnt_d[win]  = 1'b1;
                    ptr_d       = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                byte_d      = {byte_q[6:0], 1'b0};
                work_hist_d = window[HIST_W-1:0];
                work_fill_d = fill_nx;
                work_cnt_d  = work_cnt_q + CNT_W'(hit);
                bit_d       = bit_q + 3'd1;
                if (hist_clr[cur_q]) kill_d = 1'b1;
                if (bit_q == 3'd7) begin
                    done_d      = 1'b1;
                    done_id_d   = cur_q;
                    match_cnt_d = work_cnt_q + CNT_W'(hit);
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (!kill_q) begin
                    hist_d[cur_q] = work_hist_q;
                    fill_d[cur_q] = work_fill_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Clears applied last so they override a same-edge writeback
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (hist_clr[i]) begin
                hist_d[i] = '0;
                fill_d[i] = '0;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            cur_q       <= '0;
            byte_q      <= '0;
            bit_q       <= '0;
            work_hist_q <= '0;
            work_fill_q <= '0;
            work_cnt_q  <= '0;
            kill_q      <= 1'b0;
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                hist_q[i] <= '0;
                fill_q[i] <= '0;
            end
            gnt_q       <= '0;
            done_q      <= 1'b0;
            done_id_q   <= '0;
            match_cnt_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            cur_q       <= cur_d;
            byte_q      <= byte_d;
            bit_q       <= bit_d;
            work_hist_q <= work_hist_d;
            work_fill_q <= work_fill_d;
            work_cnt_q  <= work_cnt_d;
            kill_q      <= kill_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            done_id_q   <= done_id_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign done_id   = done_id_q;
    assign match_cnt = match_cnt_q;

endmodule
